// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : funct3 codes, FSM state encoding and the access helpers used
//               by the dmem_responder data-memory endpoint.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_FMT  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Store codes share encodings with LB/LH/LW; unsigned loads may not store.
    function automatic logic is_legal(input logic we, input logic [2:0] f3,
                                      input logic [1:0] off);
        logic w_ok;
        case (f3)
            F3_LB:   w_ok = 1'b1;
            F3_LH:   w_ok = ~off[0];
            F3_LW:   w_ok = (off == 2'b00);
            F3_LBU:  w_ok = ~we;
            F3_LHU:  w_ok = ~we & ~off[0];
            default: w_ok = 1'b0;
        endcase
        return w_ok;
    endfunction

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [7:0]  w_byte;
        logic [15:0] w_half;
        logic [31:0] w_res;
        case (off)
            2'd0:    w_byte = word[7:0];
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            default: w_byte = word[31:24];
        endcase
        w_half = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_LB:   w_res = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  w_res = {24'h0, w_byte};
            F3_LH:   w_res = {{16{w_half[15]}}, w_half};
            F3_LHU:  w_res = {16'h0, w_half};
            F3_LW:   w_res = word;
            default: w_res = 32'h0;
        endcase
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_byte_bank.sv
`default_nettype none
// ============================================================================
// Module      : dmem_byte_bank
// Description : One byte lane of data memory; synchronous read-first RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_byte_bank #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_din,
    output logic [7:0]        o_dout
);

    logic [7:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_din;
            end
            o_dout <= r_mem[i_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Load/store responder over valid/ready channels with
//               configurable wait states and misalignment/funct3 error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 13,
    parameter int LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam logic [3:0] c_cnt_init = 4'(LATENCY - 1);

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_cnt;
    logic               r_we, r_err, r_rsp_err;
    logic [ADDR_W+1:0]  r_addr;
    logic [2:0]         r_f3;
    logic [31:0]        r_wdata, r_rdata;
    logic               w_accept, w_legal, w_ram_en;
    logic [3:0]         w_lane_we;
    logic [31:0]        w_lane_din, w_ram_word;
    logic               w_unused_addr_hi;

    // Bits above the bank index are ignored, so addresses wrap.
    assign w_unused_addr_hi = |req_addr_i[31:ADDR_W+2];

    assign w_legal  = is_legal(req_we_i, req_funct3_i, req_addr_i[1:0]);
    assign w_accept = req_valid_i & req_ready_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        w_ram_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    w_state_nxt = w_legal ? ST_WAIT : ST_FMT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_ram_en    = 1'b1;
                    w_state_nxt = ST_FMT;
                end
            end
            ST_FMT: begin
                w_state_nxt = ST_RESP;
            end
            default: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cnt     <= 4'd0;
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            r_addr    <= '0;
            r_f3      <= 3'd0;
            r_wdata   <= 32'h0;
            r_rdata   <= 32'h0;
            r_rsp_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we_i;
                r_addr  <= req_addr_i[ADDR_W+1:0];
                r_f3    <= req_funct3_i;
                r_wdata <= req_wdata_i;
                r_err   <= ~w_legal;
                r_cnt   <= c_cnt_init;
            end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == ST_FMT) begin
                r_rdata   <= (r_err | r_we) ? 32'h0 : fmt_load(r_f3, r_addr[1:0], w_ram_word);
                r_rsp_err <= r_err;
            end else if (r_state == ST_RESP && rsp_ready_i) begin
                r_rdata   <= 32'h0;
                r_rsp_err <= 1'b0;
            end
        end
    end

    // Sub-word stores replicate the data across lanes; the mask picks the target.
    always_comb begin
        w_lane_we  = 4'b0000;
        w_lane_din = {4{r_wdata[7:0]}};
        case (r_f3)
            F3_SW: begin
                w_lane_we  = 4'b1111;
                w_lane_din = r_wdata;
            end
            F3_SH: begin
                w_lane_we  = r_addr[1] ? 4'b1100 : 4'b0011;
                w_lane_din = {2{r_wdata[15:0]}};
            end
            default: begin
                w_lane_we = 4'b0001 << r_addr[1:0];
            end
        endcase
    end

    for (genvar g = 0; g < 4; g++) begin : g_bank
        dmem_byte_bank #(
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk    (clk_i),
            .i_en   (w_ram_en),
            .i_we   (r_we & w_lane_we[g]),
            .i_addr (r_addr[ADDR_W+1:2]),
            .i_din  (w_lane_din[8*g +: 8]),
            .o_dout (w_ram_word[8*g +: 8])
        );
    end

    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed bench; instance 0 runs LATENCY=1, instance 1 LATENCY=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n     [2];
    logic        req_valid [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [2:0]  req_f3    [2];
    logic [31:0] req_wdata [2];
    logic        rsp_ready [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(13), .LATENCY(1)) u_dut1 (
        .clk_i (clk), .rst_ni (rst_n[0]),
        .req_valid_i (req_valid[0]), .req_ready_o (req_ready[0]),
        .req_we_i (req_we[0]), .req_addr_i (req_addr[0]),
        .req_funct3_i (req_f3[0]), .req_wdata_i (req_wdata[0]),
        .rsp_valid_o (rsp_valid[0]), .rsp_ready_i (rsp_ready[0]),
        .rsp_rdata_o (rsp_rdata[0]), .rsp_err_o (rsp_err[0])
    );

    dmem_responder #(.ADDR_W(13), .LATENCY(3)) u_dut3 (
        .clk_i (clk), .rst_ni (rst_n[1]),
        .req_valid_i (req_valid[1]), .req_ready_o (req_ready[1]),
        .req_we_i (req_we[1]), .req_addr_i (req_addr[1]),
        .req_funct3_i (req_f3[1]), .req_wdata_i (req_wdata[1]),
        .rsp_valid_o (rsp_valid[1]), .rsp_ready_i (rsp_ready[1]),
        .rsp_rdata_o (rsp_rdata[1]), .rsp_err_o (rsp_err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One request/response; hold = cycles rsp_ready stays low after rsp_valid rises.
    task automatic xact(input int s, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                        input string tag);
        int n;
        @(negedge clk);
        check({tag, " req_ready idle"}, 32'(req_ready[s]), 32'd1);
        req_valid[s] = 1'b1;
        req_we[s]    = we;
        req_f3[s]    = f3;
        req_addr[s]  = addr;
        req_wdata[s] = wdata;
        rsp_ready[s] = 1'b0;
        @(posedge clk); #1;
        req_valid[s] = 1'b0;
        n = 0;
        while (rsp_valid[s] !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " rdata"}, rsp_rdata[s], exp_rdata);
        check({tag, " err"}, 32'(rsp_err[s]), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " hold valid"}, 32'(rsp_valid[s]), 32'd1);
            check({tag, " hold rdata"}, rsp_rdata[s], exp_rdata);
            check({tag, " hold req_ready"}, 32'(req_ready[s]), 32'd0);
        end
        @(negedge clk);
        rsp_ready[s] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[s] = 1'b0;
        check({tag, " post valid"}, 32'(rsp_valid[s]), 32'd0);
        check({tag, " post rdata"}, rsp_rdata[s], 32'h0);
        check({tag, " post req_ready"}, 32'(req_ready[s]), 32'd1);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst_n[s]     = 1'b0;
            req_valid[s] = 1'b0;
            req_we[s]    = 1'b0;
            req_addr[s]  = 32'h0;
            req_f3[s]    = 3'd0;
            req_wdata[s] = 32'h0;
            rsp_ready[s] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            check("reset req_ready", 32'(req_ready[s]), 32'd1);
            check("reset rsp_valid", 32'(rsp_valid[s]), 32'd0);
            check("reset rdata", rsp_rdata[s], 32'h0);
            check("reset err", 32'(rsp_err[s]), 32'd0);
        end

        // LATENCY = 1 instance
        xact(0, 1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 0, 32'h0,        1'b0, 2, "SW 10");
        xact(0, 1'b0, 3'b010, 32'h10,   32'h0,        0, 32'hDEADBEEF, 1'b0, 2, "LW 10");
        xact(0, 1'b1, 3'b000, 32'h13,   32'hFFFFFF80, 0, 32'h0,        1'b0, 2, "SB 13");
        xact(0, 1'b0, 3'b000, 32'h13,   32'h0,        0, 32'hFFFFFF80, 1'b0, 2, "LB 13");
        xact(0, 1'b0, 3'b100, 32'h13,   32'h0,        0, 32'h00000080, 1'b0, 2, "LBU 13");
        xact(0, 1'b0, 3'b010, 32'h10,   32'h0,        0, 32'h80ADBEEF, 1'b0, 2, "LW 10 after SB");
        xact(0, 1'b0, 3'b001, 32'h12,   32'h0,        0, 32'hFFFF80AD, 1'b0, 2, "LH 12");
        xact(0, 1'b0, 3'b101, 32'h10,   32'h0,        0, 32'h0000BEEF, 1'b0, 2, "LHU 10");
        xact(0, 1'b0, 3'b001, 32'h10,   32'h0,        0, 32'hFFFFBEEF, 1'b0, 2, "LH 10");
        xact(0, 1'b1, 3'b010, 32'h20,   32'hCAFEF00D, 0, 32'h0,        1'b0, 2, "SW 20");
        xact(0, 1'b1, 3'b001, 32'h21,   32'h00001234, 0, 32'h0,        1'b1, 1, "SH 21 misaligned");
        xact(0, 1'b0, 3'b010, 32'h20,   32'h0,        0, 32'hCAFEF00D, 1'b0, 2, "LW 20 unchanged");
        xact(0, 1'b1, 3'b001, 32'h22,   32'hFFFF1234, 0, 32'h0,        1'b0, 2, "SH 22");
        xact(0, 1'b1, 3'b000, 32'h21,   32'hAAAAAA55, 0, 32'h0,        1'b0, 2, "SB 21");
        xact(0, 1'b0, 3'b010, 32'h20,   32'h0,        0, 32'h1234550D, 1'b0, 2, "LW 20 after SH/SB");
        xact(0, 1'b0, 3'b011, 32'h20,   32'h0,        0, 32'h0,        1'b1, 1, "funct3 011");
        xact(0, 1'b1, 3'b100, 32'h20,   32'h0,        0, 32'h0,        1'b1, 1, "store f3 100");
        xact(0, 1'b0, 3'b010, 32'h12,   32'h0,        0, 32'h0,        1'b1, 1, "LW 12 misaligned");
        xact(0, 1'b0, 3'b101, 32'h11,   32'h0,        0, 32'h0,        1'b1, 1, "LHU 11 misaligned");
        xact(0, 1'b0, 3'b010, 32'h8010, 32'h0,        0, 32'h80ADBEEF, 1'b0, 2, "LW 8010 wrap");
        xact(0, 1'b0, 3'b010, 32'h8020, 32'h0,        0, 32'h1234550D, 1'b0, 2, "LW 8020 wrap");

        // LATENCY = 3 instance
        xact(1, 1'b1, 3'b010, 32'h40,   32'hA5A55A5A, 0, 32'h0,        1'b0, 4, "L3 SW 40");
        xact(1, 1'b0, 3'b010, 32'h40,   32'h0,        5, 32'hA5A55A5A, 1'b0, 4, "L3 LW 40 hold");
        xact(1, 1'b1, 3'b001, 32'h43,   32'h0,        0, 32'h0,        1'b1, 1, "L3 SH 43 err");

        // Store aborted by reset while waiting
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_f3[1]    = 3'b010;
        req_addr[1]  = 32'h40;
        req_wdata[1] = 32'h12345678;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        check("L3 accept into wait", 32'(req_ready[1]), 32'd0);
        @(negedge clk);
        rst_n[1] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst_n[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("reset-in-wait rsp_valid", 32'(rsp_valid[1]), 32'd0);
            check("reset-in-wait req_ready", 32'(req_ready[1]), 32'd1);
        end
        xact(1, 1'b0, 3'b010, 32'h40,   32'h0,        0, 32'hA5A55A5A, 1'b0, 4, "L3 LW 40 after abort");

        // Reset and accept on the same edge: reset wins
        @(negedge clk);
        rst_n[1]     = 1'b0;
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_f3[1]    = 3'b010;
        req_addr[1]  = 32'h40;
        req_wdata[1] = 32'h0BADF00D;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        rst_n[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("reset+accept rsp_valid", 32'(rsp_valid[1]), 32'd0);
            check("reset+accept req_ready", 32'(req_ready[1]), 32'd1);
        end
        xact(1, 1'b0, 3'b010, 32'h40,   32'h0,        0, 32'hA5A55A5A, 1'b0, 4, "L3 LW 40 after reset+accept");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
